iterative_multiplier_8x8: RTL and testbench



---
 rtl/iterative_multiplier_8x8.sv | 143 ++++++++++++++
 tb/tb_iterative_multiplier_8x8.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_multiplier_8x8.sv
// iterative_multiplier_8x8: multi-cycle unsigned square multiplier built around
// one shared external 4x4 combinational multiplier. Each CALC cycle presents one
// nibble pair on mul_a/mul_b and accumulates the shifted 8-bit product.
// Optional feature macro: ITERATIVE_MULT_EARLY_ZERO_EN (zero operand short-cut).
module iterative_multiplier_8x8 #(
  parameter int N_NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*N_NIBBLES-1:0] a,
  input  logic [4*N_NIBBLES-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_NIBBLES-1:0] product,
  output logic                   busy,
  output logic [3:0]             mul_a,
  output logic [3:0]             mul_b,
  input  logic [7:0]             mul_product
);

  localparam int W  = 4 * N_NIBBLES;
  localparam int PW = 2 * W;
  localparam int S  = N_NIBBLES * N_NIBBLES;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   step;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [PW-1:0]   acc;

  logic [31:0]     nib_i;
  logic [31:0]     nib_j;
  logic [31:0]     shamt;
  logic [W-1:0]    sh_a;
  logic [W-1:0]    sh_b;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   sum;
  logic            last_step;
  logic            skip;

  // Step decode: nibble indices, shifted partial product and running sum
  always_comb begin
    nib_i     = 32'(step) % 32'(N_NIBBLES);
    nib_j     = 32'(step) / 32'(N_NIBBLES);
    shamt     = (nib_i + nib_j) << 2;
    sh_a      = op_a >> (nib_i << 2);
    sh_b      = op_b >> (nib_j << 2);
    partial   = PW'(mul_product) << shamt;
    sum       = acc + partial;
    last_step = (step == SW'(S - 1));
  end

`ifdef ITERATIVE_MULT_EARLY_ZERO_EN
  // Zero operand: spend one CALC cycle with the multiplier idle, then finish
  // with a zero result, giving out_valid one edge after acceptance.
  always_comb begin
    skip = (op_a == '0) || (op_b == '0);
  end
`else
  // Zero operands follow the normal full-length path
  always_comb begin
    skip = 1'b0;
  end
`endif

  // Nibble pair to the shared 4x4 multiplier, quiet outside CALC
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == CALC && !skip) begin
      mul_a = sh_a[3:0];
      mul_b = sh_b[3:0];
    end
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (skip || last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, step counter, accumulator and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      step    <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= a;
            op_b <= b;
            acc  <= '0;
            step <= '0;
          end
        end
        CALC: begin
          if (skip) begin
            acc     <= '0;
            product <= '0;
          end else begin
            acc <= sum;
            if (last_step) product <= sum;
            else           step    <= step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier_8x8.sv
// tb_iterative_multiplier_8x8: directed and randomized transactions checked
// every cycle against a timeline model of the multiplier (product = a*b,
// result after S edges, nibble schedule k -> (a nibble k%N, b nibble k/N)).
module tb_iterative_multiplier_8x8;

  localparam int N = 2;
  localparam int W = 4 * N;
  localparam int S = N * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
  logic [3:0]     mul_a;
  logic [3:0]     mul_b;
  logic [7:0]     mul_product;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  iterative_multiplier_8x8 #(.N_NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product)
  );

  // External 4x4 multiplier
  assign mul_product = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int unsigned idx);
    logic [W-1:0] t;
    t = v >> (4 * idx);
    return t[3:0];
  endfunction

  // Timeline model state
  bit             active = 0;
  int unsigned    cyc = 0;
  int unsigned    acc_cyc = 0;
  int unsigned    lat = S;
  int unsigned    calc_len = S;
  logic [W-1:0]   ma = '0;
  logic [W-1:0]   mb = '0;
  logic [2*W-1:0] exp_prod = '0;

  // Compare every output once per cycle, away from the active edge
  always @(negedge clk) begin
    int unsigned k;
    logic        e_ov;
    logic [3:0]  e_ma;
    logic [3:0]  e_mb;
    logic        zop;
    cyc++;
    e_ov = 1'b0;
    e_ma = '0;
    e_mb = '0;
    if (rst) begin
      active   = 0;
      exp_prod = '0;
    end else if (active) begin
      k = cyc - acc_cyc - 1;
      if (k >= lat) begin
        e_ov     = 1'b1;
        exp_prod = 16'(ma) * 16'(mb);
      end
      if (k < calc_len) begin
        e_ma = nib(ma, k % N);
        e_mb = nib(mb, k / N);
      end
    end
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("in_ready", 32'(in_ready), 32'(!active));
    chk("busy", 32'(busy), 32'(active));
    chk("mul_a", 32'(mul_a), 32'(e_ma));
    chk("mul_b", 32'(mul_b), 32'(e_mb));
    chk("product", 32'(product), 32'(exp_prod));
    if (!rst) begin
      if (active && e_ov && out_ready) begin
        active = 0;
      end else if (!active && in_valid) begin
        active  = 1;
        acc_cyc = cyc;
        ma      = a;
        mb      = b;
        zop     = (a == '0) || (b == '0);
`ifdef ITERATIVE_MULT_EARLY_ZERO_EN
        lat      = zop ? 1 : S;
        calc_len = zop ? 0 : S;
`else
        zop      = 1'b0;
        lat      = S;
        calc_len = S;
`endif
      end
    end
  end

  task automatic wait_ready(input string tag);
    int unsigned t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) chk(tag, 32'(out_valid), 32'd1);
  endtask

  // One transaction; bp = cycles of out_ready low once the result is up
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int unsigned bp);
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    wait_ready("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    wait_valid("done_timeout");
    repeat (bp) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h12, 8'h34, 0);

    // Back-to-back with in_valid held; second operands change during CALC
    a = 8'h0A; b = 8'h0B; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready("b2b_accept1");
    @(posedge clk); #1;
    a = 8'h80; b = 8'h02;
    wait_ready("b2b_accept2");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("b2b_done2");
    @(posedge clk); #1;
    out_ready = 1'b0;

    run_op(8'h20, 8'h35, 5);

    // Reset in CALC step 2
    a = 8'h55; b = 8'h66; in_valid = 1'b1; out_ready = 1'b1;
    wait_ready("rst_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;

    run_op(8'h03, 8'h05, 0);
    run_op(8'h00, 8'h7F, 0);
    run_op(8'h7F, 8'h00, 2);
    run_op(8'h00, 8'h00, 0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(0, 7) == 0) x = '0;
      if ($urandom_range(0, 7) == 0) y = '0;
      run_op(x, y, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
